async_pipe_reg: RTL
===================

Name: async_pipe_reg

Overview:
- Parametrised successor to the single 8-bit asynchronous-reset data register.
- A DEPTH-stage, WIDTH-bit register pipeline with valid/ready flow control per stage, an occupancy count and bubble collapsing.
- Sits between a producer and consumer in the datapath.
- Used wherever fixed retiming latency plus backpressure is needed.
- Every stage is cleared by the asynchronous active-low reset.

Parameters:
- WIDTH, 8, data bit width (>=1)
- DEPTH, 3, number of register stages (>=1); elaboration error if 0

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset; asserting it clears all state immediately
- in_valid  input  1  producer offers data_in this cycle
- in_ready  output  1  pipeline accepts data_in this cycle
- data_in  input  WIDTH  input data
- out_valid  output  1  data_out is valid
- out_ready  input  1  consumer accepts data_out this cycle
- data_out  output  WIDTH  last-stage data
- count  output  $clog2(DEPTH+1)  number of occupied stages

Behaviour:
- Reset (rst=0, asynchronous): all stage valid bits=0, all stage data=0.
  - Hence out_valid=0, data_out=0, count=0.
  - in_ready=1 during and after reset.
- Reset mid-operation discards all in-flight data with no output handshake.
- Release is synchronous to the next clk edge.
- Stage i (0=input, DEPTH-1=output) holds v[i], d[i].
- ready chain (combinational):
  - ready[DEPTH-1] = !v[DEPTH-1] || out_ready
  - ready[i] = !v[i] || ready[i+1]
  - in_ready = ready[0]
- Transfer rules:
  - Stage i loads from stage i-1 (or from the input for i=0) when ready[i]=1.
  - v[i] <= upstream valid; d[i] <= upstream data only when upstream valid=1.
  - Data holds on bubbles; no toggling.
- Bubble collapsing: an empty stage accepts new data even when downstream is stalled, so a stalled pipe fills completely to DEPTH entries.
- Latency: with no stall, a word accepted at edge N appears on data_out after edge N+DEPTH-1.
  - out_valid is high in the cycle following edge N+DEPTH-1.
  - Throughput is 1 word/cycle.
- Output handshake: a word leaves when out_valid && out_ready.
  - data_out stays stable while out_valid && !out_ready.
- Full (count=DEPTH) with out_ready=0: in_ready=0. Producer must hold in_valid/data_in; no data is lost.
- Full with out_ready=1: in_ready=1 in the same cycle (pass-through ready). Simultaneous accept and emit leaves count unchanged.
- Empty: out_valid=0. data_out shows the last stage data (0 after reset).
- count updates each edge: +1 on accept only, -1 on emit only, unchanged on both or neither.
  - count equals the popcount of v[].
- No combinational path from in_valid/data_in to any output.
- The only combinational path is out_ready -> in_ready.

Optional Feature:
- Macro ASYNC_PIPE_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit, synchronous, active-high).
  - On a clk edge with flush=1, all v[] <= 0 and count <= 0; d[] is retained.
  - in_ready=0 while flush=1, and any in_valid that cycle is not accepted.
  - An out_valid && out_ready that cycle still counts as emitted.
  - Asynchronous reset takes priority over flush.
- Undefined: no flush port; behaviour exactly as above.

Decomposition:
- Package async_pipe_pkg:
  - function for count width, clog2-based.
  - typedef stage_t struct {logic v; logic [WIDTH-1:0] d} via parameterised class/typedef pattern.
  - localparam default WIDTH/DEPTH.
- One sub-module, async_pipe_stage:
  - Single valid+data register with asynchronous active-low reset.
  - Inputs: up_valid, up_data, load.
  - Outputs: v, d.
- Top generates DEPTH instances plus the ready chain and counter.

Test Plan (WIDTH=8, DEPTH=3, clocking block driving outputs #3 after posedge and sampling #1step):
- Reset: rst=0 mid-simulation after loading 2 words -> out_valid=0, data_out=0, count=0, in_ready=1 immediately, without waiting for clk.
- Streaming: out_ready=1, drive data_in=0..7 on consecutive cycles -> data_out=0..7 on consecutive cycles, first word after 3 edges; count reaches 3 and stays there.
- Backpressure fill: out_ready=0, drive 0xA1,0xA2,0xA3,0xA4 -> first three accepted, count=3, in_ready=0 and 0xA4 held; data_out=0xA1 stable. Then out_ready=1 -> 0xA1..0xA4 emitted in order, no loss or duplication.
- Bubbles: in_valid pattern 1,0,1,0 with data 0x11,x,0x22,x and out_ready=1 -> out_valid pattern 1,0,1,0 delayed 3 cycles; data_out 0x11 then 0x22; count never exceeds 2.
- Simultaneous accept/emit at full: count=3, in_valid=1, out_ready=1 -> in_ready=1, count stays 3, ordering preserved.
- With ASYNC_PIPE_FLUSH_EN: load 3 words, pulse flush for 1 cycle with in_valid=1 -> next cycle count=0, out_valid=0, the offered word is not accepted.

Source files
------------

// File: rtl/async_pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : async_pipe_pkg
// Description : Shared constants, count-width helper and stage record type
//               for the async_pipe_reg valid/ready register pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package async_pipe_pkg;

  // Default geometry: one byte wide, three stages deep.
  localparam int c_DEFAULT_WIDTH = 8;
  localparam int c_DEFAULT_DEPTH = 3;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  // A degenerate depth still yields a legal one-bit vector so that the
  // dedicated elaboration check reports the problem instead of a width error.
  function automatic int count_width(input int depth);
    if (depth < 1) begin
      return 1;
    end
    return $clog2(depth + 1);
  endfunction

  // One pipeline slot at the default width: a valid flag and its payload.
  // The top level declares the same shape locally at its own WIDTH.
  typedef struct packed {
    logic                       v;
    logic [c_DEFAULT_WIDTH-1:0] d;
  } stage_t;

endpackage
`default_nettype wire

// File: rtl/async_pipe_reg_stage.sv
`default_nettype none
// ============================================================================
// Module      : async_pipe_stage
// Description : One valid+data slot of the async_pipe_reg pipeline. On a
//               load edge the valid bit follows the upstream valid; the data
//               word is captured only when the upstream word is valid, so
//               the payload holds steady across bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module async_pipe_stage
  import async_pipe_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,       // asynchronous, active-low
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  logic             v_q;
  logic             v_d;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] d_d;

  // Next state: follow upstream on load, keep the payload through bubbles.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (load) begin
      v_d = up_valid;
      if (up_valid) begin
        d_d = up_data;
      end
    end
  end

  // Slot register, cleared at once by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v = v_q;
  assign d = d_q;

endmodule
`default_nettype wire

// File: rtl/async_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : async_pipe_reg
// Description : DEPTH-stage, WIDTH-bit register pipeline with per-stage
//               valid/ready flow control, bubble collapsing and an occupancy
//               count. All state is cleared by the asynchronous active-low
//               reset 'rst'; release takes effect at the next clk edge.
//               The only combinational path is out_ready -> in_ready.
// Options     : ASYNC_PIPE_FLUSH_EN - adds a synchronous active-high 'flush'
//               input that invalidates every stage (payloads are kept).
// Revision    : 1.0 - initial release
// ============================================================================
module async_pipe_reg
  import async_pipe_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH,
  parameter int DEPTH = c_DEFAULT_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,       // asynchronous, active-low
`ifdef ASYNC_PIPE_FLUSH_EN
  input  logic                           flush,     // synchronous, active-high
`endif
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               data_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               data_out,
  output logic [count_width(DEPTH)-1:0]  count
);

  localparam int c_CW = count_width(DEPTH);

  // Reject geometries the pipeline cannot be built with.
  if (DEPTH < 1) begin : g_bad_depth
    $error("async_pipe_reg: DEPTH must be at least 1 (got %0d)", DEPTH);
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("async_pipe_reg: WIDTH must be at least 1 (got %0d)", WIDTH);
  end

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] d;
  } pipe_stage_t;

  pipe_stage_t       w_stage [DEPTH];   // current contents of each slot
  pipe_stage_t       w_up    [DEPTH];   // word offered to each slot
  logic [DEPTH-1:0]  w_ready;
  logic [DEPTH-1:0]  w_load;
  logic              w_flush;
  logic              w_accept;
  logic              w_emit;
  logic [c_CW-1:0]   count_q;
  logic [c_CW-1:0]   count_d;

`ifdef ASYNC_PIPE_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Ready chain, walked from the output back to the input: a slot can take
  // a new word if it is empty or the slot after it is moving. A scalar
  // carry keeps the chain free of self-referencing vector bits.
  always_comb begin
    logic r_carry;
    r_carry                = !w_stage[DEPTH-1].v || out_ready;
    w_ready[DEPTH-1]       = r_carry;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      r_carry    = !w_stage[i].v || r_carry;
      w_ready[i] = r_carry;
    end
  end

  // Slot instances. Flush is folded into the normal load path: every slot
  // loads an invalid word, which clears v while leaving d untouched.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_up[g].v = in_valid && !w_flush;
      assign w_up[g].d = data_in;
    end else begin : g_body
      assign w_up[g].v = w_stage[g-1].v && !w_flush;
      assign w_up[g].d = w_stage[g-1].d;
    end

    assign w_load[g] = w_ready[g] || w_flush;

    async_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load[g]),
      .up_valid (w_up[g].v),
      .up_data  (w_up[g].d),
      .v        (w_stage[g].v),
      .d        (w_stage[g].d)
    );
  end

  // Handshake outcomes for this cycle.
  assign in_ready  = w_ready[0] && !w_flush;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = w_stage[DEPTH-1].v;
  assign data_out  = w_stage[DEPTH-1].d;
  assign w_emit    = out_valid && out_ready;

  // Occupancy next state: +1 on accept only, -1 on emit only, flush empties.
  always_comb begin
    count_d = count_q;
    if (w_flush) begin
      count_d = '0;
    end else if (w_accept && !w_emit) begin
      count_d = count_q + c_CW'(1);
    end else if (w_emit && !w_accept) begin
      count_d = count_q - c_CW'(1);
    end
  end

  // Occupancy register, tracking the number of valid slots.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire
